// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: merges store-buffer drains and load reads onto one
// single-ported memory. Loads normally win; a store wins on a RAW hazard or once
// loads have starved it for STARVE_LIMIT consecutive grants.
// Ports: clk/rst; cache_stall gates new grants; st_* store request/ack;
//        ld_* load request/ack/return data; mem_* memory command and read data;
//        busy is high while a command is in flight.
module dmem_port_arbiter #(
    // Max consecutive load grants while a store waits (legal range 1..15).
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_stall,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    output logic        st_ack,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_ack,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_next;
    logic [3:0]  starve_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        raw_hazard;
    logic        starve_hit;
    logic        grant_st;
    logic        grant_ld;

    // A load to the same word as a pending store must see the store's data,
    // so the store goes first regardless of the starvation counter.
    assign raw_hazard = st_req && ld_req && (st_addr[31:2] == ld_addr[31:2]);
    assign starve_hit = st_req && (starve_cnt == LIMIT);

    always_comb begin
        state_next = state;
        grant_st   = 1'b0;
        grant_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (!cache_stall) begin
                    if (raw_hazard || starve_hit) begin
                        grant_st = 1'b1;
                    end else if (ld_req) begin
                        grant_ld = 1'b1;
                    end else if (st_req) begin
                        grant_st = 1'b1;
                    end
                end
                if (grant_st) begin
                    state_next = WR;
                end else if (grant_ld) begin
                    state_next = RD;
                end
            end
            // In-flight commands run to completion; cache_stall is ignored here.
            WR:      state_next = IDLE;
            RD:      state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
        end else begin
            state <= state_next;
            if (grant_st) begin
                addr_q     <= st_addr;
                wdata_q    <= st_data;
                be_q       <= st_be;
                starve_cnt <= 4'd0;
            end else if (grant_ld) begin
                // Write data is left untouched on reads; byte enables go to zero.
                addr_q <= ld_addr;
                be_q   <= 4'h0;
                if (st_req && (starve_cnt != LIMIT)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end
        end
    end

    // All control outputs are pure decodes of the state register.
    assign mem_en    = (state == WR) || (state == RD);
    assign mem_we    = (state == WR);
    assign st_ack    = (state == WR);
    assign ld_ack    = (state == RD);
    assign ld_rvalid = (state == RD_WAIT);
    assign busy      = (state != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    // Memory returns read data the cycle after the command; forward it only
    // while RD_WAIT so the bus reads zero otherwise (including in reset).
    assign ld_rdata  = ld_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_stall;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_ack;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_ack;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    localparam int LIMIT = 4;

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .cache_stall(cache_stall),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ack(st_ack), .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected memory-side event: a command (write or read) or a read return.
    typedef struct {
        int          cyc;
        bit          is_rv;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
    } exp_t;

    exp_t q[$];
    exp_t me;
    exp_t ev;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: edge counter, first edge a new grant may occur,
    // consecutive loads granted while a store waited, pending read return.
    int   cyc      = 0;
    int   free_at  = 0;
    int   starve   = 0;
    bit   pend_rd  = 1'b0;
    int   pend_cyc = 0;
    bit   m_take_st;

    // Requester-side bookkeeping used by directed sequences.
    int   st_acks;
    int   ld_acks;
    int   rvalids;
    int   first_ack;
    int   ld_before_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: one grant per free slot, priority rules applied to
    // the request lines seen at the edge; stores occupy 2 edges, loads 3.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            free_at = 0;
            starve  = 0;
            pend_rd = 1'b0;
        end else begin
            cyc++;
            if (pend_rd && cyc == pend_cyc + 1) begin
                me = '{cyc: cyc, is_rv: 1'b1, we: 1'b0, addr: 32'h0,
                       wdata: 32'h0, rdata: mem_rdata, be: 4'h0};
                q.push_back(me);
                pend_rd = 1'b0;
            end
            if (cyc >= free_at && !cache_stall && (st_req || ld_req)) begin
                m_take_st = (st_req && ld_req && ((st_addr >> 2) == (ld_addr >> 2)))
                         || (st_req && starve == LIMIT)
                         || (st_req && !ld_req);
                if (m_take_st) begin
                    me = '{cyc: cyc, is_rv: 1'b0, we: 1'b1, addr: st_addr,
                           wdata: st_data, rdata: 32'h0, be: st_be};
                    starve  = 0;
                    free_at = cyc + 2;
                end else begin
                    me = '{cyc: cyc, is_rv: 1'b0, we: 1'b0, addr: ld_addr,
                           wdata: 32'h0, rdata: 32'h0, be: 4'h0};
                    if (st_req && starve < LIMIT) starve++;
                    pend_rd  = 1'b1;
                    pend_cyc = cyc;
                    free_at  = cyc + 3;
                end
                q.push_back(me);
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctrl", 32'({mem_en, mem_we, st_ack, ld_ack, ld_rvalid, busy}), 32'h0);
            chk("rst_addr", mem_addr, 32'h0);
            chk("rst_wdata", mem_wdata, 32'h0);
            chk("rst_be", 32'(mem_be), 32'h0);
            chk("rst_rdata", ld_rdata, 32'h0);
        end else begin
            chk("busy", 32'(busy), 32'(cyc < free_at - 1));
            if (mem_en) begin
                if (q.size() == 0 || q[0].is_rv) begin
                    chk("unexpected_cmd", 32'(mem_en), 32'h0);
                end else begin
                    ev = q.pop_front();
                    chk("cmd_cycle", 32'(cyc), 32'(ev.cyc));
                    chk("cmd_we", 32'(mem_we), 32'(ev.we));
                    chk("cmd_addr", mem_addr, ev.addr);
                    chk("cmd_be", 32'(mem_be), 32'(ev.be));
                    if (ev.we) chk("cmd_wdata", mem_wdata, ev.wdata);
                    chk("cmd_acks", 32'({st_ack, ld_ack}), 32'({ev.we, !ev.we}));
                end
            end else begin
                chk("idle_ctrl", 32'({mem_we, st_ack, ld_ack}), 32'h0);
            end
            if (ld_rvalid) begin
                if (q.size() == 0 || !q[0].is_rv) begin
                    chk("unexpected_rvalid", 32'(ld_rvalid), 32'h0);
                end else begin
                    ev = q.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(ev.cyc));
                    chk("rvalid_data", ld_rdata, ev.rdata);
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                ev = q.pop_front();
                if (ev.is_rv) chk("missed_rvalid", 32'(ld_rvalid), 32'h1);
                else          chk("missed_cmd", 32'(mem_en), 32'h1);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        // Small address pool so same-word store/load pairs occur often.
        return 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    // Requester behaviour: drop each request on its ack; optionally keep the
    // load request up, or issue random new traffic.
    task automatic service(input int n, input bit hold_ld, input bit rnd);
        for (int i = 0; i < n; i++) begin
            tick();
            if (st_ack) begin
                st_acks++;
                if (first_ack == 0) first_ack = 1;
                st_req = 1'b0;
            end
            if (ld_ack) begin
                ld_acks++;
                if (first_ack == 0) first_ack = 2;
                if (st_acks == 0) ld_before_st++;
                if (!hold_ld) ld_req = 1'b0;
            end
            if (ld_rvalid) rvalids++;
            if (rnd) begin
                if (!st_req && $urandom_range(0, 2) == 0) begin
                    st_req  = 1'b1;
                    st_addr = rand_addr();
                    st_data = $urandom;
                    st_be   = 4'($urandom);
                end
                if (!ld_req && $urandom_range(0, 2) == 0) begin
                    ld_req  = 1'b1;
                    ld_addr = rand_addr();
                end
                cache_stall = ($urandom_range(0, 4) == 0);
                mem_rdata   = $urandom;
            end
        end
    endtask

    task automatic clear_counts();
        st_acks = 0; ld_acks = 0; rvalids = 0; first_ack = 0; ld_before_st = 0;
    endtask

    task automatic wait_for(input bit want_st, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = want_st ? st_ack : ld_ack;
        end
        chk(name, 32'(got), 32'h1);
    endtask

    initial begin
        rst = 1'b0; cache_stall = 1'b0;
        st_req = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_be = 4'h0;
        ld_req = 1'b0; ld_addr = 32'h0; mem_rdata = 32'h0;
        clear_counts();
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Lone load.
        ld_addr = 32'h100; mem_rdata = 32'hDEADBEEF; ld_req = 1'b1;
        wait_for(1'b0, "lone_ld_ack");
        chk("lone_ld_addr", mem_addr, 32'h100);
        chk("lone_ld_we", 32'(mem_we), 32'h0);
        ld_req = 1'b0;
        tick();
        chk("lone_ld_rvalid", 32'(ld_rvalid), 32'h1);
        chk("lone_ld_rdata", ld_rdata, 32'hDEADBEEF);
        tick();

        // Lone store.
        st_addr = 32'h200; st_data = 32'h12345678; st_be = 4'b0011; st_req = 1'b1;
        wait_for(1'b1, "lone_st_ack");
        chk("lone_st_ctrl", 32'({mem_en, mem_we}), 32'h3);
        chk("lone_st_be", 32'(mem_be), 32'h3);
        st_req = 1'b0;
        tick();
        chk("lone_st_busy_after", 32'(busy), 32'h0);

        // Same-word store and load: store must go first.
        clear_counts();
        st_addr = 32'h104; st_data = 32'hA5A5_0104; st_be = 4'hF; ld_addr = 32'h106;
        st_req = 1'b1; ld_req = 1'b1;
        service(10, 1'b0, 1'b0);
        chk("raw_first_is_store", 32'(first_ack), 32'h1);
        chk("raw_load_served", 32'(ld_acks), 32'h1);

        // Starvation: loads keep coming, store must win after LIMIT loads.
        clear_counts();
        st_addr = 32'h400; st_data = 32'h0BAD_F00D; st_be = 4'hC; ld_addr = 32'h300;
        st_req = 1'b1; ld_req = 1'b1;
        service(20, 1'b1, 1'b0);
        chk("starve_loads_before_store", 32'(ld_before_st), 32'(LIMIT));
        chk("starve_store_granted", 32'(st_acks), 32'h1);
        ld_req = 1'b0;
        service(4, 1'b0, 1'b0);

        // cache_stall raised during RD: read completes, no new grant while high.
        clear_counts();
        mem_rdata = 32'hCAFE_0500;
        ld_addr = 32'h500; st_addr = 32'h600; st_data = 32'h6666_0600; st_be = 4'h5;
        ld_req = 1'b1; st_req = 1'b1;
        wait_for(1'b0, "stall_ld_ack");
        cache_stall = 1'b1;
        tick();
        chk("stall_rvalid", 32'(ld_rvalid), 32'h1);
        chk("stall_rdata", ld_rdata, 32'hCAFE_0500);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_no_grant", 32'({st_ack, ld_ack, mem_en}), 32'h0);
        end
        cache_stall = 1'b0;
        service(15, 1'b0, 1'b0);
        chk("stall_store_done", 32'(st_acks), 32'h1);

        // Reset during RD_WAIT aborts the read.
        ld_addr = 32'h700; ld_req = 1'b1;
        wait_for(1'b0, "rst_ld_ack");
        ld_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_ctrl", 32'({mem_en, ld_rvalid, ld_ack, busy}), 32'h0);
        chk("rst_async_addr", mem_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        clear_counts();
        service(6, 1'b0, 1'b0);
        chk("no_rvalid_after_rst", 32'(rvalids), 32'h0);

        // Random traffic against the model, then drain.
        service(600, 1'b0, 1'b1);
        cache_stall = 1'b0;
        service(20, 1'b0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("reqs_drained", 32'({st_req, ld_req, busy}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive load grants while a store waits; legal range 1-15.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cache_stall  in  1  blocks new grants while high.
REQ-005 st_req  in  1  store-drain request from store buffer, held until st_ack.
REQ-006 st_addr  in  32  store byte address.
REQ-007 st_data  in  32  store write data.
REQ-008 st_be  in  4  store byte enables.
REQ-009 st_ack  out  1  one-cycle pulse: store command issued to memory this cycle.
REQ-010 ld_req  in  1  load read request from memory unit, held until ld_ack.
REQ-011 ld_addr  in  32  load byte address.
REQ-012 ld_ack  out  1  one-cycle pulse: load command issued to memory this cycle.
REQ-013 ld_rvalid  out  1  one-cycle pulse: ld_rdata valid.
REQ-014 ld_rdata  out  32  load return data; equals mem_rdata when ld_rvalid is high.
REQ-015 mem_en  out  1  memory command valid.
REQ-016 mem_we  out  1  1 = write, 0 = read; meaningful only with mem_en.
REQ-017 mem_addr  out  32  memory address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_be  out  4  memory byte enables; 4'b0000 on reads.
REQ-020 mem_rdata  in  32  read data, valid the cycle after a read command.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, WR, RD, RD_WAIT; all outputs registered or decoded from state registers only.
REQ-023 In IDLE with cache_stall low, grant decision at edge N; command cycle is N+1 (WR or RD); no grant in IDLE when cache_stall high or neither request asserted.
REQ-024 Grant priority, highest first: (a) RAW hazard -- st_req && ld_req && st_addr[31:2]==ld_addr[31:2] -> store; (b) st_req && starve_cnt==STARVE_LIMIT -> store; (c) ld_req -> load; (d) st_req -> store.
REQ-025 WR cycle: mem_en=1, mem_we=1, mem_addr/mem_wdata/mem_be = values captured at grant edge, st_ack=1; next state IDLE.
REQ-026 RD cycle: mem_en=1, mem_we=0, mem_be=0, mem_addr = captured ld_addr, ld_ack=1; next state RD_WAIT.
REQ-027 RD_WAIT cycle: mem_en=0, ld_rvalid=1, ld_rdata=mem_rdata; next state IDLE.
REQ-028 Load latency SHALL be: ld_req sampled at edge N -> ld_ack in cycle N+1 -> ld_rvalid in cycle N+2; store: st_req at edge N -> st_ack in cycle N+1.
REQ-029 starve_cnt (4 bits): +1 on load grant while st_req high, saturating at STARVE_LIMIT; cleared on store grant; unchanged otherwise.
REQ-030 cache_stall SHALL NOT affect WR, RD, RD_WAIT; in-flight commands always complete.
REQ-031 Outside command cycles mem_en, mem_we, st_ack, ld_ack, ld_rvalid SHALL be 0; mem_addr/mem_wdata/mem_be hold last value.
REQ-032 Requesters dropping req before ack is outside protocol; block SHALL still complete any already-granted command.
REQ-033 At most one memory command per cycle; back-to-back grants minimum spacing: store every 2 cycles, load every 3 cycles.

Reset
REQ-034 rst high SHALL asynchronously force state IDLE, starve_cnt 0, and all outputs 0 (mem_addr, mem_wdata, ld_rdata, mem_be zero).
REQ-035 Reset during RD or RD_WAIT SHALL abort the read; no ld_rvalid after reset deasserts until a new load is granted.
REQ-036 First grant possible at first rising edge after rst deasserts.

Verification
REQ-037 Lone load: ld_req, ld_addr=0x100, mem_rdata=0xDEADBEEF -> ld_ack cycle N+1 with mem_addr=0x100, mem_we=0; ld_rvalid, ld_rdata=0xDEADBEEF cycle N+2.
REQ-038 Lone store: st_addr=0x200, st_data=0x12345678, st_be=4'b0011 -> cycle N+1 mem_en=1, mem_we=1, mem_be=4'b0011, st_ack=1; busy low at N+2.
REQ-039 RAW: st_addr=0x104, ld_addr=0x106 both requested -> store issued first, load command next grant; load never precedes store.
REQ-040 Starvation: st_req held, ld_req held with ld_addr 0x300, st_addr 0x400, STARVE_LIMIT=4 -> exactly 4 load grants, then store grant, starve_cnt back to 0.
REQ-041 cache_stall high 3 cycles during RD with ld_req/st_req pending -> RD_WAIT/ld_rvalid proceed normally; no new grant until stall drops.
REQ-042 rst pulse in RD_WAIT -> all outputs 0 immediately; ld_rvalid stays 0 for every cycle until a fresh ld_ack.
